// File: rtl/lsu_store_queue.sv
// Committed-store FIFO feeding the DCache write port, with optional
// store-to-load forwarding (define LSU_STORE_QUEUE_FORWARD_EN).
module lsu_store_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [ADDR_WIDTH-1:0]   push_addr,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic [DATA_WIDTH/8-1:0] push_wstrb,
    output logic                    dc_req_valid,
    input  logic                    dc_req_ready,
    output logic [ADDR_WIDTH-1:0]   dc_req_addr,
    output logic [DATA_WIDTH-1:0]   dc_req_data,
    output logic [DATA_WIDTH/8-1:0] dc_req_wstrb,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    output logic [DATA_WIDTH/8-1:0] ld_fwd_mask,
    output logic [DATA_WIDTH-1:0]   ld_fwd_data,
    output logic                    empty,
    output logic                    full
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] entry_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data  [DEPTH];
    logic [SW-1:0]         entry_wstrb [DEPTH];
    logic [DEPTH-1:0]      entry_valid;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic push_fire;
    logic pop_fire;

    assign full         = (count == (PW + 1)'(DEPTH));
    assign empty        = (count == '0);
    assign push_ready   = !full;
    assign dc_req_valid = !empty;
    assign push_fire    = push_valid && push_ready;
    assign pop_fire     = dc_req_valid && dc_req_ready;

    assign dc_req_addr  = entry_addr[head];
    assign dc_req_data  = entry_data[head];
    assign dc_req_wstrb = entry_wstrb[head];

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            entry_addr[tail]  <= push_addr;
            entry_data[tail]  <= push_data;
            entry_wstrb[tail] <= push_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (push_fire) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            if (pop_fire) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            unique case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef LSU_STORE_QUEUE_FORWARD_EN
    logic [PW-1:0] fwd_idx;
    logic [1:0]    unused_ld;

    assign unused_ld = ld_addr[1:0];

    // Walk oldest to youngest so younger stores overwrite older lanes.
    always_comb begin
        ld_fwd_mask = '0;
        ld_fwd_data = '0;
        fwd_idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (entry_valid[fwd_idx] &&
                entry_addr[fwd_idx][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) begin
                for (int b = 0; b < SW; b++) begin
                    if (entry_wstrb[fwd_idx][b]) begin
                        ld_fwd_mask[b]        = 1'b1;
                        ld_fwd_data[8*b +: 8] = entry_data[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld   = ^ld_addr;
    assign ld_fwd_mask = '0;
    assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_lsu_store_queue.sv
// Randomized and directed bench for lsu_store_queue against a queue-based
// reference model, checked every cycle on the falling clock edge.
module tb_lsu_store_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_addr;
    logic [31:0] push_data;
    logic [3:0]  push_wstrb;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_data;
    logic [3:0]  dc_req_wstrb;
    logic [31:0] ld_addr;
    logic [3:0]  ld_fwd_mask;
    logic [31:0] ld_fwd_data;
    logic        empty;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t q[$];

    lsu_store_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_data(push_data), .push_wstrb(push_wstrb),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .dc_req_wstrb(dc_req_wstrb),
        .ld_addr(ld_addr), .ld_fwd_mask(ld_fwd_mask), .ld_fwd_data(ld_fwd_data),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per lane, the youngest resident matching store with that strobe wins.
    task automatic model_fwd(input logic [31:0] la, output logic [3:0] m,
                             output logic [31:0] d);
        m = '0;
        d = '0;
`ifdef LSU_STORE_QUEUE_FORWARD_EN
        for (int b = 0; b < 4; b++) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a[31:2] == la[31:2] && q[i].s[b]) begin
                    m[b]        = 1'b1;
                    d[8*b +: 8] = q[i].d[8*b +: 8];
                    break;
                end
            end
        end
`endif
    endtask

    always begin
        logic        pf, pp, r;
        ent_t        e;
        logic [3:0]  em;
        logic [31:0] ed;
        @(negedge clk);
        if (started) begin
            chk("push_ready", push_ready, q.size() < DEPTH);
            chk("full", full, q.size() == DEPTH);
            chk("empty", empty, q.size() == 0);
            chk("dc_req_valid", dc_req_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("dc_req_addr", dc_req_addr, q[0].a);
                chk("dc_req_data", dc_req_data, q[0].d);
                chk("dc_req_wstrb", dc_req_wstrb, q[0].s);
            end
            model_fwd(ld_addr, em, ed);
            chk("ld_fwd_mask", ld_fwd_mask, em);
            chk("ld_fwd_data", ld_fwd_data, ed);
        end
        r  = rst;
        pf = push_valid && q.size() < DEPTH;
        pp = dc_req_ready && q.size() > 0;
        e.a = push_addr;
        e.d = push_data;
        e.s = push_wstrb;
        @(posedge clk);
        if (r) begin
            q.delete();
            started = 1'b1;
        end else if (started) begin
            if (pp) void'(q.pop_front());
            if (pf) q.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        push_wstrb = s;
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        push_valid   = 1'b0;
        push_addr    = '0;
        push_data    = '0;
        push_wstrb   = '0;
        dc_req_ready = 1'b0;
        ld_addr      = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_empty", empty, 1'b1);
        chk("rst_push_ready", push_ready, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_valid", dc_req_valid, 1'b0);
        chk("rst_mask", ld_fwd_mask, 4'h0);
        chk("rst_fdata", ld_fwd_data, 32'h0);

        push(32'h1000, 32'hDEADBEEF, 4'hF);
        chk("lat_valid", dc_req_valid, 1'b1);
        chk("lat_addr", dc_req_addr, 32'h1000);
        chk("lat_empty", empty, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", dc_req_data, 32'hDEADBEEF);
        end
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        chk("drain_empty", empty, 1'b1);

        for (int i = 0; i < 4; i++)
            push(32'h100 + 32'(i * 4), 32'(i + 7), 4'hF);
        chk("fill_full", full, 1'b1);
        chk("fill_ready", push_ready, 1'b0);
        push(32'h500, 32'h55, 4'hF);
        chk("refused_full", full, 1'b1);
        dc_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("order_addr", dc_req_addr, 32'h100 + 32'(i * 4));
            tick();
        end
        dc_req_ready = 1'b0;
        chk("order_empty", empty, 1'b1);

        push(32'h600, 32'h1, 4'h1);
        push(32'h604, 32'h2, 4'h2);
        dc_req_ready = 1'b1;
        push_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_addr  = 32'h700 + 32'(i * 4);
            push_data  = 32'(i);
            push_wstrb = 4'hF;
            tick();
        end
        push_valid   = 1'b0;
        dc_req_ready = 1'b0;
        chk("conc_full", full, 1'b0);
        chk("conc_empty", empty, 1'b0);
        chk("conc_head", dc_req_addr, 32'h748);
        dc_req_ready = 1'b1;
        tick();
        tick();
        dc_req_ready = 1'b0;

        push(32'h2000, 32'h11223344, 4'b0011);
        push(32'h2002, 32'hAA000000, 4'b1000);
        ld_addr = 32'h2000;
        #1;
`ifdef LSU_STORE_QUEUE_FORWARD_EN
        chk("fwd_mask", ld_fwd_mask, 4'b1011);
        chk("fwd_data", ld_fwd_data, 32'hAA003344);
`else
        chk("fwd_mask_off", ld_fwd_mask, 4'b0000);
        chk("fwd_data_off", ld_fwd_data, 32'h0);
`endif
        ld_addr = 32'h2004;
        #1;
        chk("miss_mask", ld_fwd_mask, 4'b0000);
        chk("miss_data", ld_fwd_data, 32'h0);
        ld_addr = 32'h2000;

        push(32'h2008, 32'h0, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_empty", empty, 1'b1);
        chk("mrst_valid", dc_req_valid, 1'b0);
        chk("mrst_ready", push_ready, 1'b1);
        chk("mrst_mask", ld_fwd_mask, 4'h0);

        for (int i = 0; i < 3000; i++) begin
            push_valid   = ($urandom_range(0, 3) != 0);
            push_addr    = 32'h3000 + 32'($urandom_range(0, 11));
            push_data    = $urandom;
            push_wstrb   = 4'($urandom);
            dc_req_ready = ($urandom_range(0, 2) == 0);
            ld_addr      = 32'h3000 + 32'($urandom_range(0, 11));
            rst          = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst          = 1'b0;
        push_valid   = 1'b0;
        dc_req_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
